// File: rtl/seg_scan_if.sv
// Requester/display bundle between the scan scheduler and its surroundings.
interface seg_scan_if;
   logic        req0;
   logic [15:0] data0;
   logic        req1;
   logic [15:0] data1;
   logic        lz_en;
   logic        gnt0;
   logic        gnt1;
   logic [3:0]  nibble;
   logic [3:0]  seg_ctrl;
   logic        frame_done;

   // Requester/board side: drives requests, watches grants and display lines.
   modport master (
      output req0, data0, req1, data1, lz_en,
      input  gnt0, gnt1, nibble, seg_ctrl, frame_done
   );

   // Scheduler side.
   modport slave (
      input  req0, data0, req1, data1, lz_en,
      output gnt0, gnt1, nibble, seg_ctrl, frame_done
   );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Four-digit seven-segment scan controller with a frame-boundary round-robin
// arbiter between two display requesters and optional leading-zero blanking.
module seg_scan_scheduler #(
   parameter int unsigned DIV_WIDTH    = 16,
   parameter int unsigned DIV_MAX      = 49999,
   parameter int unsigned BLANK_CYCLES = 4
) (
   input logic       clk,
   input logic       reset,
   seg_scan_if.slave bus
);

   localparam int unsigned BLK_W = 8;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   state_t               state;
   logic [1:0]           dig;
   logic [DIV_WIDTH-1:0] div_cnt;
   logic [BLK_W-1:0]     blk_cnt;
   logic [15:0]          disp_q;
   logic                 rr_ptr;

   logic        arb_c;
   logic        win0_c;
   logic        win1_c;
   logic [15:0] disp_nxt_c;
   logic        blk_end_c;
   logic        div_end_c;
   logic        lz_hide_c;
   logic [3:0]  nib_c;
   logic [3:0]  en_c;

   // Frame-gap arbitration and the display word that will be in effect after this edge.
   always_comb begin
      arb_c      = (state == ST_BLANK) && (dig == 2'd0) && (blk_cnt == '0);
      win0_c     = 1'b0;
      win1_c     = 1'b0;
      disp_nxt_c = disp_q;
      if (arb_c) begin
         if (bus.req0 && bus.req1) begin
            win0_c = ~rr_ptr;
            win1_c = rr_ptr;
         end else begin
            win0_c = bus.req0;
            win1_c = bus.req1;
         end
      end
      if (win0_c) begin
         disp_nxt_c = bus.data0;
      end else if (win1_c) begin
         disp_nxt_c = bus.data1;
      end
   end

   // Digit selection, leading-zero test and phase-end detection for the next SHOW cycle.
   always_comb begin
      blk_end_c = (blk_cnt == BLK_W'(BLANK_CYCLES - 1));
      div_end_c = (div_cnt == DIV_WIDTH'(DIV_MAX));
      nib_c     = 4'(disp_nxt_c >> {dig, 2'b00});
      en_c      = ~(4'b0001 << dig);
      lz_hide_c = 1'b0;
      if (bus.lz_en) begin
         case (dig)
            2'd1:    lz_hide_c = (disp_nxt_c[15:4]  == 12'h000);
            2'd2:    lz_hide_c = (disp_nxt_c[15:8]  == 8'h00);
            2'd3:    lz_hide_c = (disp_nxt_c[15:12] == 4'h0);
            default: lz_hide_c = 1'b0;
         endcase
      end
   end

   // Scan FSM, arbiter state and registered display outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_BLANK;
         dig            <= 2'd0;
         div_cnt        <= '0;
         blk_cnt        <= '0;
         disp_q         <= 16'h0000;
         rr_ptr         <= 1'b0;
         bus.seg_ctrl   <= 4'b1111;
         bus.nibble     <= 4'h0;
         bus.gnt0       <= 1'b0;
         bus.gnt1       <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.gnt0       <= win0_c;
         bus.gnt1       <= win1_c;
         bus.frame_done <= 1'b0;
         if (win0_c || win1_c) begin
            disp_q <= disp_nxt_c;
            rr_ptr <= win0_c;
         end
         case (state)
            ST_BLANK: begin
               if (blk_end_c) begin
                  state        <= ST_SHOW;
                  blk_cnt      <= '0;
                  bus.nibble   <= nib_c;
                  bus.seg_ctrl <= lz_hide_c ? 4'b1111 : en_c;
               end else begin
                  blk_cnt <= blk_cnt + BLK_W'(1);
               end
            end
            ST_SHOW: begin
               if (div_end_c) begin
                  state          <= ST_BLANK;
                  div_cnt        <= '0;
                  dig            <= dig + 2'd1;
                  bus.seg_ctrl   <= 4'b1111;
                  bus.frame_done <= (dig == 2'd3);
               end else begin
                  div_cnt      <= div_cnt + DIV_WIDTH'(1);
                  bus.nibble   <= nib_c;
                  bus.seg_ctrl <= lz_hide_c ? 4'b1111 : en_c;
               end
            end
            default: state <= ST_BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: time-indexed behavioural model plus directed
// literal checks and randomized request/lz/reset traffic.
module tb_seg_scan_scheduler;

   localparam int DIV_MAX = 3;
   localparam int BLANK   = 2;
   localparam int PER     = DIV_MAX + 1 + BLANK;
   localparam int FRAME   = 4 * PER;

   logic clk;
   logic reset;
   seg_scan_if bus ();

   seg_scan_scheduler #(
      .DIV_WIDTH   (16),
      .DIV_MAX     (DIV_MAX),
      .BLANK_CYCLES(BLANK)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit armed = 0;

   // Model state: position within the frame, display word, round-robin pointer.
   int          pos    = 0;
   logic [15:0] m_disp = 16'h0000;
   bit          m_rr   = 0;
   logic [3:0]  e_seg  = 4'hf;
   logic [3:0]  e_nib  = 4'h0;
   bit          e_g0   = 0;
   bit          e_g1   = 0;
   bit          e_fd   = 0;
   bit          e_show = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t (cyc %0d): got %h expected %h", name, $time, cyc, act, exp);
      end
   endtask

   // Behavioural reference: everything follows from the cycle index within the frame.
   always @(posedge clk) begin
      int d;
      int q;
      bit hide;
      if (!reset) begin
         pos = 0; m_disp = 16'h0000; m_rr = 0;
         e_seg = 4'hf; e_nib = 4'h0; e_g0 = 0; e_g1 = 0; e_fd = 0; e_show = 0;
      end else begin
         e_g0 = 0;
         e_g1 = 0;
         if (pos == 0) begin
            if (bus.req0 && (!bus.req1 || !m_rr)) begin
               e_g0 = 1; m_disp = bus.data0; m_rr = 1;
            end else if (bus.req1) begin
               e_g1 = 1; m_disp = bus.data1; m_rr = 0;
            end
         end
         pos    = (pos + 1) % FRAME;
         e_fd   = (pos == 0);
         d      = pos / PER;
         q      = pos % PER;
         e_show = (q >= BLANK);
         if (e_show) begin
            e_nib = 4'((m_disp >> (4 * d)) & 16'h000f);
            hide  = bus.lz_en && (d != 0) && ((m_disp >> (4 * d)) == 16'h0000);
            e_seg = hide ? 4'b1111 : ~(4'b0001 << d);
         end else begin
            e_seg = 4'b1111;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (armed) begin
         cmp("seg_ctrl", 16'(bus.seg_ctrl), 16'(e_seg));
         cmp("gnt0", 16'(bus.gnt0), 16'(e_g0));
         cmp("gnt1", 16'(bus.gnt1), 16'(e_g1));
         cmp("frame_done", 16'(bus.frame_done), 16'(e_fd));
         if (e_show) cmp("nibble", 16'(bus.nibble), 16'(e_nib));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      cyc = 0;
   endtask

   task automatic go(input int k);
      while (cyc < k) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic lit(input string name, input logic [3:0] seg, input logic [3:0] nib);
      cmp({name, "_seg"}, 16'(bus.seg_ctrl), 16'(seg));
      cmp({name, "_nib"}, 16'(bus.nibble), 16'(nib));
   endtask

   initial begin
      reset     = 1'b0;
      bus.req0  = 1'b0;
      bus.req1  = 1'b0;
      bus.data0 = 16'h0000;
      bus.data1 = 16'h0000;
      bus.lz_en = 1'b0;
      @(posedge clk);
      armed = 1;
      #1;
      lit("rst_state", 4'b1111, 4'h0);

      // No requests: plain scan of a zero word.
      do_reset();
      go(1);  cmp("a_blank1", 16'(bus.seg_ctrl), 16'hf);
      go(2);  lit("a_d0", 4'b1110, 4'h0);
      go(5);  cmp("a_d0_end", 16'(bus.seg_ctrl), 16'he);
      go(6);  cmp("a_gap", 16'(bus.seg_ctrl), 16'hf);
      go(8);  cmp("a_d1", 16'(bus.seg_ctrl), 16'hd);
      go(14); cmp("a_d2", 16'(bus.seg_ctrl), 16'hb);
      go(20); cmp("a_d3", 16'(bus.seg_ctrl), 16'h7);
      go(23); cmp("a_fd_early", 16'(bus.frame_done), 16'h0);
      go(24); cmp("a_fd", 16'(bus.frame_done), 16'h1);
      go(25); cmp("a_fd_once", 16'(bus.frame_done), 16'h0);

      // req0 with A5C3 held through reset.
      bus.req0 = 1'b1; bus.data0 = 16'hA5C3;
      do_reset();
      go(1);  cmp("b_gnt0", 16'(bus.gnt0), 16'h1);
      bus.req0 = 1'b0;
      go(2);  lit("b_d0", 4'b1110, 4'h3);
      go(8);  lit("b_d1", 4'b1101, 4'hC);
      go(14); lit("b_d2", 4'b1011, 4'h5);
      go(20); lit("b_d3", 4'b0111, 4'hA);

      // Both requesting continuously: grants alternate per frame gap.
      bus.req0 = 1'b1; bus.data0 = 16'h1111;
      bus.req1 = 1'b1; bus.data1 = 16'h2222;
      do_reset();
      go(1);  cmp("c_g0_f0", 16'(bus.gnt0), 16'h1);
      go(2);  cmp("c_nib_f0", 16'(bus.nibble), 16'h1);
      go(25); cmp("c_g1_f1", 16'(bus.gnt1), 16'h1);
              cmp("c_g0_f1", 16'(bus.gnt0), 16'h0);
      go(26); cmp("c_nib_f1", 16'(bus.nibble), 16'h2);
      go(49); cmp("c_g0_f2", 16'(bus.gnt0), 16'h1);
      go(50); cmp("c_nib_f2", 16'(bus.nibble), 16'h1);
      bus.req0 = 1'b0; bus.req1 = 1'b0;

      // Leading-zero suppression on 0040, then 0000.
      bus.lz_en = 1'b1; bus.req0 = 1'b1; bus.data0 = 16'h0040;
      do_reset();
      go(1);  bus.req0 = 1'b0;
      go(2);  lit("d_d0", 4'b1110, 4'h0);
      go(8);  lit("d_d1", 4'b1101, 4'h4);
      go(14); cmp("d_d2", 16'(bus.seg_ctrl), 16'hf);
      go(20); cmp("d_d3", 16'(bus.seg_ctrl), 16'hf);
      go(24); bus.req0 = 1'b1; bus.data0 = 16'h0000;
      go(25); cmp("d_gnt0", 16'(bus.gnt0), 16'h1);
      bus.req0 = 1'b0;
      go(26); lit("d_z0", 4'b1110, 4'h0);
      go(32); cmp("d_z1", 16'(bus.seg_ctrl), 16'hf);
      go(44); cmp("d_z3", 16'(bus.seg_ctrl), 16'hf);
      bus.lz_en = 1'b0;

      // req1 raised mid-frame, then reset during digit 2 SHOW.
      do_reset();
      go(8);  bus.req1 = 1'b1; bus.data1 = 16'hBEEF;
      go(9);  cmp("e_no_gnt", 16'(bus.gnt1), 16'h0);
      go(25); cmp("e_gnt1", 16'(bus.gnt1), 16'h1);
      bus.req1 = 1'b0;
      go(26); lit("e_d0", 4'b1110, 4'hF);
      go(32); lit("e_d1", 4'b1101, 4'hE);
      go(38); lit("e_d2", 4'b1011, 4'hE);
      go(39);
      #2 reset = 1'b0;
      #1 lit("f_async", 4'b1111, 4'h0);
      @(negedge clk);
      #2 reset = 1'b1;
      cyc = 0;
      go(2);  lit("f_restart", 4'b1110, 4'h0);
      go(8);  lit("f_d1", 4'b1101, 4'h0);

      // Randomized traffic with hold-until-grant requesters.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bus.gnt0) bus.req0 = 1'b0;
         if (bus.gnt1) bus.req1 = 1'b0;
         if (!bus.req0 && $urandom_range(0, 15) == 0) begin
            bus.data0 = 16'($urandom) >> $urandom_range(0, 16);
            bus.req0  = 1'b1;
         end
         if (!bus.req1 && $urandom_range(0, 15) == 0) begin
            bus.data1 = 16'($urandom) >> $urandom_range(0, 16);
            bus.req1  = 1'b1;
         end
         if (bus.req0 && $urandom_range(0, 99) == 0) bus.req0 = 1'b0;
         if (bus.req1 && $urandom_range(0, 99) == 0) bus.req1 = 1'b0;
         if ($urandom_range(0, 39) == 0) bus.lz_en = ~bus.lz_en;
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk);
            #2 reset = 1'b1;
         end
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
